// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: one outstanding word request to instruction memory,
// returned words buffered with their PCs in a small FIFO toward decode.
module ysyx_22040237_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        inst_ready
);

    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [63:0]        fetch_pc;
    logic [63:0]        req_pc;
    logic [31:0]        data_mem [DEPTH];
    logic [63:0]        pc_mem   [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               req_fire;
    logic               push;
    logic               pop;

    // redirect_valid is the only input allowed to reach an output combinationally.
    assign imem_req_valid = rst && (state == IDLE) && (count < FULL) && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push = rst && (state == WAIT) && imem_rsp_valid && !redirect_valid;

    assign inst_valid = rst && (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign inst       = inst_valid ? data_mem[rd_ptr] : 32'd0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : 64'd0;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (req_fire) state_next = WAIT;
            WAIT: begin
                if (imem_rsp_valid)      state_next = IDLE;
                else if (redirect_valid) state_next = DROP;
            end
            DROP: if (imem_rsp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[63:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (req_fire) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 64'd4;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; count gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: doc/ysyx_22040237_ifu.md
# ysyx_22040237_ifu

Instruction fetch unit for the ysyx_22040237 core, directly upstream of the decode stage. It holds the fetch PC, issues one word request at a time to instruction memory over a valid/ready handshake, and buffers returned instructions with their PCs in a small FIFO. Decode drains that FIFO through a valid/ready interface. A redirect input (branch/jump target) flushes buffered and in-flight fetches and restarts fetch at a new PC.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000, fetch PC loaded at reset
- DEPTH, 2, instruction FIFO entries (power of two, ≥2)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset (0 = reset)
- imem_req_valid  output  1  fetch request valid
- imem_req_addr  output  64  fetch address; always word-aligned
- imem_req_ready  input  1  memory accepts request
- imem_rsp_valid  input  1  instruction word returned (one per accepted request, ≥1 cycle later)
- imem_rsp_data  input  32  instruction word
- redirect_valid  input  1  restart fetch at redirect_pc
- redirect_pc  input  64  new fetch PC; bits [1:0] ignored (treated as 0)
- inst_valid  output  1  FIFO head valid toward decode
- inst  output  32  FIFO head instruction; 0 when inst_valid=0
- inst_pc  output  64  PC of head instruction; 0 when inst_valid=0
- inst_ready  input  1  decode consumes head

## Operation
- State: fetch_pc (64b), req_pc (64b, address of the outstanding request), FIFO (data + pc, rd/wr pointers, count 0..DEPTH), 2-bit FSM.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request accepted, response pending.
  - DROP: one request outstanding whose response must be discarded.
- imem_req_valid = rst & (state==IDLE) & (count < DEPTH) & ~redirect_valid. imem_req_addr = fetch_pc.
- Request handshake (valid & ready):
  - req_pc ← fetch_pc
  - fetch_pc ← fetch_pc + 4 (mod 2^64; wraps to 0)
  - IDLE → WAIT
- WAIT + imem_rsp_valid, no redirect: push {imem_rsp_data, req_pc}, then WAIT → IDLE.
- DROP + imem_rsp_valid: discard the word, then DROP → IDLE.
- imem_rsp_valid while in IDLE is a protocol violation. It is ignored and no push occurs.
- Pop when inst_valid & inst_ready. Push and pop in the same cycle are both honoured, so count is unchanged.
- Overflow cannot occur: a request is only issued when count < DEPTH, and at most one request is outstanding.
- Redirect (redirect_valid=1) has priority over every other event that cycle:
  - fetch_pc ← {redirect_pc[63:2], 2'b00}
  - FIFO cleared (count, pointers ← 0); any simultaneous pop or push is discarded
  - FSM: IDLE→IDLE; WAIT→DROP, except that if imem_rsp_valid arrives that same cycle, the word is discarded and WAIT→IDLE; DROP→DROP, or DROP→IDLE if imem_rsp_valid arrives that cycle.
  - No request is issued in the redirect cycle.
- Reset (rst=0), including mid-transaction:
  - fetch_pc ← RESET_PC; req_pc ← 0; FSM ← IDLE; FIFO cleared.
  - Outputs during reset: imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0; imem_req_addr shows RESET_PC from the first cycle after the reset edge.
  - The memory side must also be reset. Responses to pre-reset requests are not tracked.

## Timing
- First request: imem_req_valid=1 with addr RESET_PC in the first cycle rst=1.
- Response in cycle N → inst_valid=1 in cycle N+1 (FIFO output is registered state; no combinational rsp→inst path).
- Next request: earliest in cycle N+1. Peak throughput is one instruction per 2 cycles with a 1-cycle memory.
- Redirect in cycle R → first request to the new PC in cycle R+1 if the FSM is IDLE then. From DROP, the request issues one cycle after the discarded response.
- Downstream backpressure: with inst_ready=0, the FIFO fills to DEPTH, then imem_req_valid=0. It reasserts the cycle after a pop.
- Combinational paths: only redirect_valid → imem_req_valid. No path from inst_ready or imem_req_ready to any output.

## Test plan
- Reset/boot: hold rst=0 3 cycles, release; 1-cycle memory returns 32'h00100093 at 0x8000_0000 → imem_req_addr=0x8000_0000 in first cycle; inst=32'h00100093, inst_pc=0x8000_0000 with inst_valid=1 in the cycle after the response; next imem_req_addr=0x8000_0004.
- Backpressure: inst_ready=0, memory always ready → exactly 2 requests (0x…00, 0x…04), FIFO count 2, imem_req_valid stays 0. Then raise inst_ready one cycle → head 0x…00 popped; request to 0x…08 issues the next cycle.
- Redirect in WAIT: response delayed 3 cycles; assert redirect_valid with redirect_pc=0x8000_0103 during the wait → the delayed word is dropped and never appears on inst; the next request addr is 0x8000_0100; the FIFO is empty the cycle after the redirect.
- Redirect colliding with response and pop: FIFO holds 1 entry with inst_ready=1; imem_rsp_valid and redirect_valid in the same cycle → the following cycle has inst_valid=0 and FSM IDLE, then a request to the redirect target.
- Wrap-around: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC → second request addr is 64'h0; inst_pc values are …FFFC then 0.
- Mid-transaction reset: assert rst=0 while in WAIT with 2 entries buffered → next cycle inst_valid=0, imem_req_valid=0; after release, fetch restarts at RESET_PC.
